ddp_merge_arbiter: RTL and testbench

Two-into-one merge arbiter for the data-driven pipeline. It lets two upstream self-timed stages, each speaking a Send/Ack 4-phase bundled-data handshake, share one downstream stage. It synchronizes the asynchronous handshake lines into a single clock domain and picks a winner round-robin. It registers the winner's packet, drives the downstream handshake, and returns the acknowledge to the granted requester only.

---
 rtl/ddp_merge_arbiter.sv | 121 ++++++++++++
 tb/tb_ddp_merge_arbiter.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddp_merge_arbiter.sv
// rtl/ddp_merge_arbiter.sv - two-into-one round-robin merge of 4-phase Send/Ack stages
// Asynchronous handshake lines are synchronized; the FSM sees only the last synchronizer stage.
module ddp_merge_arbiter #(
   parameter int DATA_W      = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic              CLK,
   input  logic              MR_n,
   input  logic              Send_in0,
   input  logic [DATA_W-1:0] Data_in0,
   output logic              Ack_out0,
   input  logic              Send_in1,
   input  logic [DATA_W-1:0] Data_in1,
   output logic              Ack_out1,
   output logic              Send_out,
   output logic [DATA_W-1:0] Data_out,
   input  logic              Ack_in,
   output logic              CP,
   output logic              Grant,
   output logic              Busy
);

   typedef enum logic [1:0] {IDLE, SEND, RELEASE} state_t;

   state_t            state, state_n;
   logic [SYNC_STAGES-1:0] sync0, sync1, synca;
   logic              req0_s, req1_s, ack_s;
   logic              send_q, send_n;
   logic              ack_q, ack_n;
   logic              grant_q, grant_n;
   logic              last_g, last_n;
   logic              cp_q, cp_n;
   logic [DATA_W-1:0] data_q, data_n;
   logic              winner, req_g;

   always_ff @(posedge CLK or negedge MR_n) begin
      if (!MR_n) begin
         sync0 <= '0;
         sync1 <= '0;
         synca <= '0;
      end else begin
         sync0 <= {sync0[SYNC_STAGES-2:0], Send_in0};
         sync1 <= {sync1[SYNC_STAGES-2:0], Send_in1};
         synca <= {synca[SYNC_STAGES-2:0], Ack_in};
      end
   end

   assign req0_s = sync0[SYNC_STAGES-1];
   assign req1_s = sync1[SYNC_STAGES-1];
   assign ack_s  = synca[SYNC_STAGES-1];

   // On a tie the requester that did not win last time goes first.
   assign winner = (req0_s & req1_s) ? ~last_g : req1_s;
   assign req_g  = grant_q ? req1_s : req0_s;

   always_ff @(posedge CLK or negedge MR_n) begin
      if (!MR_n) begin
         state   <= IDLE;
         send_q  <= 1'b0;
         ack_q   <= 1'b0;
         grant_q <= 1'b0;
         last_g  <= 1'b1;
         cp_q    <= 1'b0;
         data_q  <= '0;
      end else begin
         state   <= state_n;
         send_q  <= send_n;
         ack_q   <= ack_n;
         grant_q <= grant_n;
         last_g  <= last_n;
         cp_q    <= cp_n;
         data_q  <= data_n;
      end
   end

   always_comb begin
      state_n = state;
      send_n  = send_q;
      ack_n   = ack_q;
      grant_n = grant_q;
      last_n  = last_g;
      cp_n    = 1'b0;
      data_n  = data_q;
      case (state)
         IDLE: begin
            if ((req0_s | req1_s) & ~ack_s) begin
               grant_n = winner;
               data_n  = winner ? Data_in1 : Data_in0;
               cp_n    = 1'b1;
               send_n  = 1'b1;
               state_n = SEND;
            end
         end
         SEND: begin
            // Requester withdrawal here is ignored; the packet is already committed.
            if (ack_s) begin
               send_n  = 1'b0;
               ack_n   = 1'b1;
               state_n = RELEASE;
            end
         end
         RELEASE: begin
            if (~req_g & ~ack_s) begin
               ack_n   = 1'b0;
               last_n  = grant_q;
               state_n = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   assign Send_out = send_q;
   assign Data_out = data_q;
   assign CP       = cp_q;
   assign Grant    = grant_q;
   assign Busy     = (state != IDLE);
   assign Ack_out0 = ack_q & ~grant_q;
   assign Ack_out1 = ack_q & grant_q;

endmodule

// File: tb/tb_ddp_merge_arbiter.sv
// tb/tb_ddp_merge_arbiter.sv - bench for ddp_merge_arbiter
module tb_ddp_merge_arbiter;

   localparam int S = 2;

   logic        CLK, MR_n;
   logic        Send_in0, Send_in1, Ack_in;
   logic [15:0] Data_in0, Data_in1;
   logic        Ack_out0, Ack_out1, Send_out, CP, Grant, Busy;
   logic [15:0] Data_out;

   logic        t2_send, t2_ack, t2_zero;
   logic [15:0] t2_data, t2_zdata;
   logic        t2_ack0, t2_ack1, t2_sout, t2_cp, t2_grant, t2_busy;
   logic [15:0] t2_dout;

   int total = 0;
   int bad   = 0;

   ddp_merge_arbiter #(.DATA_W(16), .SYNC_STAGES(2)) dut (
      .CLK(CLK), .MR_n(MR_n),
      .Send_in0(Send_in0), .Data_in0(Data_in0), .Ack_out0(Ack_out0),
      .Send_in1(Send_in1), .Data_in1(Data_in1), .Ack_out1(Ack_out1),
      .Send_out(Send_out), .Data_out(Data_out), .Ack_in(Ack_in),
      .CP(CP), .Grant(Grant), .Busy(Busy)
   );

   ddp_merge_arbiter #(.DATA_W(16), .SYNC_STAGES(3)) dut3 (
      .CLK(CLK), .MR_n(MR_n),
      .Send_in0(t2_send), .Data_in0(t2_data), .Ack_out0(t2_ack0),
      .Send_in1(t2_zero), .Data_in1(t2_zdata), .Ack_out1(t2_ack1),
      .Send_out(t2_sout), .Data_out(t2_dout), .Ack_in(t2_ack),
      .CP(t2_cp), .Grant(t2_grant), .Busy(t2_busy)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   task automatic chk1(input string name, input logic act, input logic exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%b required=%b t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic at_drive();
      @(posedge CLK);
      #2;
   endtask

   task automatic at_sample();
      @(posedge CLK);
      #1;
   endtask

   // Background upstream sources and downstream sink
   int          left0 = 0, left1 = 0;
   logic [15:0] base0 = 16'h0, base1 = 16'h0, cnt0 = 16'h0, cnt1 = 16'h0;
   int          ds_delay = 2, ds_hold = 0;

   initial forever begin
      at_drive();
      if (MR_n) begin
         if (Send_in0 && Ack_out0) Send_in0 = 1'b0;
         else if (!Send_in0 && !Ack_out0 && left0 > 0) begin
            Data_in0 = base0 + cnt0;
            cnt0++;
            Send_in0 = 1'b1;
            left0--;
         end
      end
   end

   initial forever begin
      at_drive();
      if (MR_n) begin
         if (Send_in1 && Ack_out1) Send_in1 = 1'b0;
         else if (!Send_in1 && !Ack_out1 && left1 > 0) begin
            Data_in1 = base1 + cnt1;
            cnt1++;
            Send_in1 = 1'b1;
            left1--;
         end
      end
   end

   initial begin : downstream
      int c;
      c = 0;
      forever begin
         at_drive();
         if (!MR_n) begin
            Ack_in = 1'b0;
            c = 0;
         end else if (Send_out && !Ack_in) begin
            if (c >= ds_delay) begin Ack_in = 1'b1; c = 0; end
            else c++;
         end else if (!Send_out && Ack_in) begin
            if (c >= ds_hold) begin Ack_in = 1'b0; c = 0; end
            else c++;
         end else c = 0;
      end
   end

   // Transaction log of what the DUT actually did
   logic [16:0] log_q[$];
   int ack0_rises, ack1_rises, ack0_high;
   logic pa0 = 1'b0, pa1 = 1'b0;

   initial forever begin
      at_sample();
      if (MR_n) begin
         if (CP) log_q.push_back({Grant, Data_out});
         if (Ack_out0 && !pa0) ack0_rises++;
         if (Ack_out1 && !pa1) ack1_rises++;
         if (Ack_out0) ack0_high++;
      end
      pa0 = Ack_out0;
      pa1 = Ack_out1;
   end

   // Reference model: per edge, the handshake phase advances on what the
   // synchronized view (inputs seen S edges earlier) shows.
   initial begin : model
      logic [S-1:0] h0, h1, ha;
      logic i0, i1, ia, r0, r1, a, w;
      logic [15:0] d0, d1;
      int   ph;
      logic m_send, m_ack, m_grant, m_last, m_cp;
      logic [15:0] m_data;
      h0 = '0; h1 = '0; ha = '0; ph = 0;
      m_send = 0; m_ack = 0; m_grant = 0; m_last = 1; m_cp = 0; m_data = '0;
      forever begin
         @(posedge CLK);
         i0 = Send_in0; i1 = Send_in1; ia = Ack_in; d0 = Data_in0; d1 = Data_in1;
         if (!MR_n) begin
            h0 = '0; h1 = '0; ha = '0; ph = 0;
            m_send = 0; m_ack = 0; m_grant = 0; m_last = 1; m_cp = 0; m_data = '0;
         end else begin
            r0 = h0[S-1]; r1 = h1[S-1]; a = ha[S-1];
            m_cp = 0;
            if (ph == 0) begin
               if ((r0 || r1) && !a) begin
                  if (r0 && r1) w = !m_last;
                  else w = r1;
                  m_grant = w;
                  m_data = w ? d1 : d0;
                  m_cp = 1; m_send = 1; ph = 1;
               end
            end else if (ph == 1) begin
               if (a) begin m_send = 0; m_ack = 1; ph = 2; end
            end else begin
               if (!(m_grant ? r1 : r0) && !a) begin
                  m_ack = 0; m_last = m_grant; ph = 0;
               end
            end
            h0 = {h0[S-2:0], i0};
            h1 = {h1[S-2:0], i1};
            ha = {ha[S-2:0], ia};
         end
         #1;
         chk1("m_send_out", Send_out, m_send);
         chk1("m_ack_out0", Ack_out0, m_ack && !m_grant);
         chk1("m_ack_out1", Ack_out1, m_ack && m_grant);
         chk1("m_cp", CP, m_cp);
         chk1("m_grant", Grant, m_grant);
         chk1("m_busy", Busy, ph != 0);
         chk16("m_data_out", Data_out, m_data);
      end
   end

   task automatic wait_idle(input string name, input int budget);
      int k;
      k = 0;
      while ((Busy || Ack_in || Send_in0 || Send_in1 || Ack_out0 || Ack_out1 ||
              left0 > 0 || left1 > 0) && k < budget) begin
         at_sample();
         k++;
      end
      chk1(name, k < budget, 1'b1);
   endtask

   task automatic do_reset();
      at_drive();
      MR_n = 1'b0;
      left0 = 0; left1 = 0;
      Send_in0 = 1'b0; Send_in1 = 1'b0; Ack_in = 1'b0;
      at_drive();
      at_drive();
      MR_n = 1'b1;
   endtask

   initial begin
      int k;
      logic [16:0] e;
      MR_n = 1'b0;
      Send_in0 = 0; Send_in1 = 0; Ack_in = 0; Data_in0 = '0; Data_in1 = '0;
      t2_send = 0; t2_ack = 0; t2_zero = 0; t2_data = '0; t2_zdata = '0;
      ack0_rises = 0; ack1_rises = 0; ack0_high = 0;
      at_drive();
      at_drive();
      chk1("rst_send_out", Send_out, 1'b0);
      chk1("rst_busy", Busy, 1'b0);
      chk1("rst_grant", Grant, 1'b0);
      chk16("rst_data_out", Data_out, 16'h0);
      MR_n = 1'b1;

      // Single request on port 0
      ds_delay = 5;
      at_drive();
      Data_in0 = 16'h1234; Send_in0 = 1'b1;
      at_sample(); chk1("t1_e1_send", Send_out, 1'b0);
      at_sample(); chk1("t1_e2_send", Send_out, 1'b0);
      at_sample();
      chk1("t1_e3_send", Send_out, 1'b1);
      chk16("t1_e3_data", Data_out, 16'h1234);
      chk1("t1_e3_cp", CP, 1'b1);
      chk1("t1_e3_grant", Grant, 1'b0);
      chk1("t1_e3_busy", Busy, 1'b1);
      at_sample(); chk1("t1_e4_cp", CP, 1'b0);
      k = 0;
      while (!Ack_in && k < 50) begin at_sample(); k++; end
      chk1("t1_ack_in_seen", k < 50, 1'b1);
      chk1("t1_ack0_n", Ack_out0, 1'b0);
      at_sample(); chk1("t1_ack0_n1", Ack_out0, 1'b0);
      at_sample();
      chk1("t1_ack0_n2", Ack_out0, 1'b1);
      chk1("t1_send_n2", Send_out, 1'b0);
      chk1("t1_ack1_n2", Ack_out1, 1'b0);
      wait_idle("t1_idle_timeout", 100);
      ds_delay = 2;

      // Simultaneous requests right after reset
      do_reset();
      log_q.delete(); ack0_rises = 0; ack1_rises = 0;
      base0 = 16'hAAAA; cnt0 = 0; base1 = 16'h5555; cnt1 = 0;
      left0 = 1; left1 = 1;
      wait_idle("t2_idle_timeout", 200);
      chk1("t2_count", log_q.size() == 2, 1'b1);
      if (log_q.size() == 2) begin
         chk1("t2_first_grant", log_q[0][16], 1'b0);
         chk16("t2_first_data", log_q[0][15:0], 16'hAAAA);
         chk1("t2_second_grant", log_q[1][16], 1'b1);
         chk16("t2_second_data", log_q[1][15:0], 16'h5555);
      end
      chk1("t2_ack0_once", ack0_rises == 1, 1'b1);
      chk1("t2_ack1_once", ack1_rises == 1, 1'b1);

      // Both ports continuously busy for six transactions
      at_drive();
      log_q.delete(); ack0_rises = 0; ack1_rises = 0;
      base0 = 16'h0A00; cnt0 = 0; base1 = 16'h0B00; cnt1 = 0;
      left0 = 3; left1 = 3;
      wait_idle("t3_idle_timeout", 600);
      chk1("t3_count", log_q.size() == 6, 1'b1);
      for (int i = 0; i < 6 && i < log_q.size(); i++) begin
         e = log_q[i];
         chk1("t3_grant_seq", e[16], 1'(i % 2));
         chk16("t3_data_seq", e[15:0], ((i % 2) ? 16'h0B00 : 16'h0A00) + 16'(i / 2));
      end
      chk1("t3_ack0_three", ack0_rises == 3, 1'b1);
      chk1("t3_ack1_three", ack1_rises == 3, 1'b1);

      // Downstream holds Ack_in high while port 1 waits
      at_drive();
      log_q.delete(); ack0_high = 0; ds_hold = 10;
      base0 = 16'h0400; cnt0 = 0; left0 = 1;
      at_drive();
      at_drive();
      base1 = 16'h0411; cnt1 = 0; left1 = 1;
      wait_idle("t4_idle_timeout", 300);
      chk1("t4_count", log_q.size() == 2, 1'b1);
      if (log_q.size() == 2) begin
         chk1("t4_first_grant", log_q[0][16], 1'b0);
         chk1("t4_second_grant", log_q[1][16], 1'b1);
         chk16("t4_second_data", log_q[1][15:0], 16'h0411);
      end
      chk1("t4_ack0_held", ack0_high >= 10, 1'b1);
      ds_hold = 0;

      // Reset while in SEND
      ds_delay = 20;
      at_drive();
      base0 = 16'h0777; cnt0 = 0; left0 = 1;
      k = 0;
      while (!Send_out && k < 50) begin at_sample(); k++; end
      chk1("t5_send_seen", k < 50, 1'b1);
      #3;
      MR_n = 1'b0;
      #1;
      chk1("t5_send_out", Send_out, 1'b0);
      chk1("t5_ack0", Ack_out0, 1'b0);
      chk1("t5_ack1", Ack_out1, 1'b0);
      chk1("t5_busy", Busy, 1'b0);
      chk1("t5_cp", CP, 1'b0);
      chk16("t5_data_out", Data_out, 16'h0);
      left0 = 0; left1 = 0; Send_in0 = 1'b0; Send_in1 = 1'b0; Ack_in = 1'b0;
      ds_delay = 2;
      at_drive();
      at_drive();
      MR_n = 1'b1;
      log_q.delete();
      base0 = 16'h0100; cnt0 = 0; base1 = 16'h0200; cnt1 = 0;
      left0 = 1; left1 = 1;
      wait_idle("t5_idle_timeout", 200);
      chk1("t5_count", log_q.size() == 2, 1'b1);
      if (log_q.size() >= 1) begin
         chk1("t5_tie_grant", log_q[0][16], 1'b0);
         chk16("t5_tie_data", log_q[0][15:0], 16'h0100);
      end

      // Three-stage synchronizer instance
      at_drive();
      t2_data = 16'hBEEF; t2_send = 1'b1;
      at_sample(); chk1("t6_e1_send", t2_sout, 1'b0);
      at_sample(); chk1("t6_e2_send", t2_sout, 1'b0);
      at_sample(); chk1("t6_e3_send", t2_sout, 1'b0);
      at_sample();
      chk1("t6_e4_send", t2_sout, 1'b1);
      chk16("t6_e4_data", t2_dout, 16'hBEEF);
      #1;
      t2_ack = 1'b1;
      at_sample(); chk1("t6_ack_n", t2_ack0, 1'b0);
      at_sample(); chk1("t6_ack_n1", t2_ack0, 1'b0);
      at_sample(); chk1("t6_ack_n2", t2_ack0, 1'b0);
      at_sample();
      chk1("t6_ack_n3", t2_ack0, 1'b1);
      chk1("t6_send_n3", t2_sout, 1'b0);
      #1;
      t2_send = 1'b0; t2_ack = 1'b0;
      at_sample(); chk1("t6_rel_m", t2_ack0, 1'b1);
      at_sample(); chk1("t6_rel_m1", t2_ack0, 1'b1);
      at_sample(); chk1("t6_rel_m2", t2_ack0, 1'b1);
      at_sample();
      chk1("t6_rel_m3", t2_ack0, 1'b0);
      chk1("t6_busy_m3", t2_busy, 1'b0);
      chk1("t6_ack1", t2_ack1, 1'b0);

      at_sample();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1);
   end

endmodule
